// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// Holds the FSM state encoding, BCD limits and seven-segment patterns.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle between a requester and the serial BCD adder.
// The requester owns start/operands/seg_idx; the adder owns the results.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  localparam int IW = $clog2(DIGITS);

  logic                  start;
  logic                  mode_sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic [IW-1:0]         seg_idx;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;
  logic [6:0]            seg;

  modport master (
    output start, mode_sub, a, b, cin, seg_idx,
    input  busy, done, sum, cout, err, seg
  );

  modport slave (
    input  start, mode_sub, a, b, cin, seg_idx,
    output busy, done, sum, cout, err, seg
  );

endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// One BCD digit of add or nine's-complement subtract with decimal carry.
// Illegal digits go through the same rule so the result is deterministic.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] i_ad,
  input  logic [3:0] i_bd,
  input  logic       i_ci,
  input  logic       i_sub,
  output logic [3:0] o_digit,
  output logic       o_co,
  output logic       o_bad
);

  logic [3:0] w_bd;
  logic [4:0] w_t;
  logic [3:0] w_adj;
  logic       w_big;

  assign w_bd  = i_sub ? (BCD_MAX - i_bd) : i_bd;
  assign w_t   = {1'b0, i_ad} + {1'b0, w_bd}
               + {4'b0, i_ci};
  assign w_big = (w_t > {1'b0, BCD_MAX});
  assign w_adj = w_t[3:0] + BCD_CORR;

  assign o_digit = w_big ? w_adj : w_t[3:0];
  assign o_co    = w_big;
  assign o_bad   = (i_ad > BCD_MAX)
                 | (i_bd > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor, LSD first.
// Start/busy/done handshake, sticky bad-digit flag, 7-seg result view.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit SUB_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_sum;
  logic          r_c;
  logic          r_sub;
  logic          r_busy;
  logic          r_done;
  logic          r_cout;
  logic          r_err;

  logic          w_accept;
  logic          w_last;
  logic          w_sub;
  logic          w_in_bad;
  logic [3:0]    w_digit;
  logic          w_co;
  logic          w_bad;
  logic [3:0]    w_sel;
  logic          w_hit;
  logic [6:0]    w_seg;

  assign w_sub    = SUB_EN & bus.mode_sub;
  assign w_accept = (r_state == IDLE) & bus.start;
  assign w_last   = (r_state == RUN)
                  & (r_idx == IW'(DIGITS - 1));

  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > BCD_MAX ||
          bus.b[4*i +: 4] > BCD_MAX)
        w_in_bad = 1'b1;
    end
  end

  bcd_digit_add u_dig (
    .i_ad    (r_a[3:0]),
    .i_bd    (r_b[3:0]),
    .i_ci    (r_c),
    .i_sub   (r_sub),
    .o_digit (w_digit),
    .o_co    (w_co),
    .o_bad   (w_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_work <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_sub  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_sub  <= w_sub;
        r_c    <= w_sub | bus.cin;
        r_idx  <= '0;
        r_busy <= 1'b1;
        r_err  <= w_in_bad;
      end else if (r_state == RUN) begin
        // operands shift down so digit 0 always feeds the adder
        r_a    <= r_a >> 4;
        r_b    <= r_b >> 4;
        r_work <= {w_digit, r_work[W-1:4]};
        r_c    <= w_co;
        r_idx  <= r_idx + 1'b1;
        r_err  <= r_err | w_bad;
        if (w_last) begin
          r_sum  <= {w_digit, r_work[W-1:4]};
          r_cout <= w_co;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel = 4'd0;
    w_hit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.seg_idx == IW'(i)) begin
        w_sel = r_sum[4*i +: 4];
        w_hit = 1'b1;
      end
    end
    w_seg = w_hit ? seg_decode(w_sel) : 7'b0;
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.err  = r_err;
  assign bus.seg  = w_seg;

endmodule
